// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_pkg
// Brief    : Shared widths, logical off pattern and divider helpers for the
//            multi-digit 7-segment display engine.
// Revision : 1.0
// ============================================================================
package seg_display_pkg;

    localparam int SEG_W = 7;

    // Off pattern before the output polarity is applied.
    localparam logic [SEG_W-1:0] SEG_OFF = '0;

    // Bit width needed to count 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

    // Clock cycles per event when 'parts' events share one period of rate_hz.
    function automatic int calc_div(input int clk_hz, input int rate_hz, input int parts);
        if (rate_hz * parts <= 0) begin
            return 0;
        end
        return clk_hz / (rate_hz * parts);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : seg_tick_gen
// Brief    : Modulo-DIV counter with synchronous clear; emits a one-cycle tick
//            on the last count of each period.
// Revision : 1.0
// ============================================================================
module seg_tick_gen
    import seg_display_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = clog2_min1(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_LAST);
    // A clear restarts the period, so the wrap it overrides is not reported.
    assign tick = wrap && !clr;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_engine.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_engine
// Brief    : Double-buffered N-digit 7-segment driver with blink, blanking,
//            PWM dimming and optional multiplexed scan outputs.
// Revision : 1.0
// ============================================================================
module seg_display_engine
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int SCAN_HZ    = 1000,
    parameter int MUX_MODE   = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
    input  logic                        load,
    input  logic [2:0]                  dim_level,
    output logic [SEG_W*NUM_DIGITS-1:0] seg_out,
    output logic [SEG_W-1:0]            scan_seg,
    output logic [NUM_DIGITS-1:0]       scan_an,
    output logic                        blink_phase
);

    localparam int BLINK_DIV = calc_div(CLK_HZ, 2 * BLINK_HZ, 1);
    localparam int SCAN_DIV  = calc_div(CLK_HZ, SCAN_HZ, NUM_DIGITS);
    localparam int IDX_W     = clog2_min1(NUM_DIGITS);
    localparam int PAT_W     = SEG_W * NUM_DIGITS;

    localparam logic                  OFF_BIT      = (ACTIVE_LOW != 0);
    localparam logic [PAT_W-1:0]      SEG_OUT_OFF  = {PAT_W{OFF_BIT}};
    localparam logic [SEG_W-1:0]      SCAN_SEG_OFF = {SEG_W{OFF_BIT}};
    localparam logic [NUM_DIGITS-1:0] SCAN_AN_OFF  = {NUM_DIGITS{OFF_BIT}};
    localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
            $error("seg_display_engine: NUM_DIGITS must be within 1..16");
        end
        if (BLINK_DIV < 1) begin : g_bad_blink_div
            $error("seg_display_engine: BLINK_DIV evaluates below 1");
        end
        if (MUX_MODE != 0 && SCAN_DIV < 1) begin : g_bad_scan_div
            $error("seg_display_engine: SCAN_DIV evaluates below 1");
        end
    endgenerate

    logic [PAT_W-1:0]      pat_q,         pat_d;
    logic [NUM_DIGITS-1:0] blink_mask_q,  blink_mask_d;
    logic [NUM_DIGITS-1:0] blank_mask_q,  blank_mask_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [2:0]            pwm_cnt_q,     pwm_cnt_d;
    logic [IDX_W-1:0]      scan_idx_q,    scan_idx_d;
    logic [PAT_W-1:0]      seg_out_q,     seg_out_d;
    logic [SEG_W-1:0]      scan_seg_q,    scan_seg_d;
    logic [NUM_DIGITS-1:0] scan_an_q,     scan_an_d;

    logic                  blink_restart;
    logic                  blink_tick;
    logic                  scan_tick;
    logic                  pwm_gate;
    logic [PAT_W-1:0]      vis;
    logic [SEG_W-1:0]      scan_vis;
    logic [NUM_DIGITS-1:0] scan_onehot;

    // A newly loaded mask restarts the blink period in the visible half.
    assign blink_restart = load && (blink_mask != blink_mask_q);

    seg_tick_gen #(
        .DIV   (BLINK_DIV)
    ) u_blink_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (blink_restart),
        .tick  (blink_tick)
    );

    generate
        if (MUX_MODE != 0) begin : g_scan_tick
            seg_tick_gen #(
                .DIV   (SCAN_DIV)
            ) u_scan_tick (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (1'b0),
                .tick  (scan_tick)
            );
        end else begin : g_no_scan_tick
            assign scan_tick = 1'b0;
        end
    endgenerate

    always_comb begin
        pat_d        = pat_q;
        blink_mask_d = blink_mask_q;
        blank_mask_d = blank_mask_q;
        if (load) begin
            pat_d        = seg_in;
            blink_mask_d = blink_mask;
            blank_mask_d = blank_mask;
        end

        blink_phase_d = blink_phase_q;
        if (blink_restart) begin
            blink_phase_d = 1'b1;
        end else if (blink_tick) begin
            blink_phase_d = ~blink_phase_q;
        end

        pwm_cnt_d = pwm_cnt_q + 3'd1;

        scan_idx_d = scan_idx_q;
        if (scan_tick) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
        end
    end

    assign pwm_gate = (pwm_cnt_q <= dim_level);

    // Post-blink/blank/PWM pattern per digit, plus the digit under the scan index.
    always_comb begin
        vis         = '0;
        scan_vis    = SEG_OFF;
        scan_onehot = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (pwm_gate && !blank_mask_q[d] && !(blink_mask_q[d] && !blink_phase_q)) begin
                vis[d*SEG_W +: SEG_W] = pat_q[d*SEG_W +: SEG_W];
            end else begin
                vis[d*SEG_W +: SEG_W] = SEG_OFF;
            end
            if (scan_idx_q == IDX_W'(d)) begin
                scan_vis       = vis[d*SEG_W +: SEG_W];
                scan_onehot[d] = 1'b1;
            end
        end
    end

    // XOR with the off level applies the board polarity in one step.
    always_comb begin
        seg_out_d  = vis ^ SEG_OUT_OFF;
        scan_seg_d = SCAN_SEG_OFF;
        scan_an_d  = SCAN_AN_OFF;
        if (MUX_MODE != 0) begin
            scan_seg_d = scan_vis ^ SCAN_SEG_OFF;
            scan_an_d  = scan_onehot ^ SCAN_AN_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q         <= '0;
            blink_mask_q  <= '0;
            blank_mask_q  <= '0;
            blink_phase_q <= 1'b1;
            pwm_cnt_q     <= '0;
            scan_idx_q    <= '0;
            seg_out_q     <= SEG_OUT_OFF;
            scan_seg_q    <= SCAN_SEG_OFF;
            scan_an_q     <= SCAN_AN_OFF;
        end else begin
            pat_q         <= pat_d;
            blink_mask_q  <= blink_mask_d;
            blank_mask_q  <= blank_mask_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_d;
            scan_idx_q    <= scan_idx_d;
            seg_out_q     <= seg_out_d;
            scan_seg_q    <= scan_seg_d;
            scan_an_q     <= scan_an_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign scan_seg    = scan_seg_q;
    assign scan_an     = scan_an_q;
    assign blink_phase = blink_phase_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_engine
// Brief    : Scoreboard bench for seg_display_engine (4 digits, mux, active-low).
// Revision : 1.0
// ============================================================================
module tb_seg_display_engine;

    localparam logic [27:0] PAT_B = {7'h66, 7'h4F, 7'h5B, 7'h06};
    localparam logic [27:0] PAT_C = {7'h7F, 7'h6D, 7'h07, 7'h3F};

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        load       = 1'b0;
    logic [27:0] seg_in     = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  blank_mask = '0;
    logic [2:0]  dim_level  = 3'd7;
    logic [27:0] seg_out;
    logic [6:0]  scan_seg;
    logic [3:0]  scan_an;
    logic        blink_phase;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        int          sel;
        logic [27:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    // Bench-side view of what the display should hold, with the edge each change lands.
    logic [27:0] m_pat, m_pat_old;
    logic [3:0]  m_bm, m_bm_old, m_bk, m_bk_old;
    int          m_ld, m_base, m_base_prev, m_dim, m_dim_old, m_dim_edge;

    seg_display_engine #(
        .NUM_DIGITS (4),
        .CLK_HZ     (100),
        .BLINK_HZ   (5),
        .SCAN_HZ    (5),
        .MUX_MODE   (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .blink_mask  (blink_mask),
        .blank_mask  (blank_mask),
        .load        (load),
        .dim_level   (dim_level),
        .seg_out     (seg_out),
        .scan_seg    (scan_seg),
        .scan_an     (scan_an),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Blink phase held after edge k; restarts are recorded as base edges.
    function automatic bit phase_at(input int k);
        int b;
        b = (k >= m_base) ? m_base : m_base_prev;
        return (((k - b) / 10) % 2) == 0;
    endfunction

    // Logical (active-high) lit pattern from state after edge s, dim sampled at edge k.
    function automatic logic [27:0] model_vis(input int s, input int k);
        logic [27:0] pat, v;
        logic [3:0]  bm, bk;
        int          dim;
        bit          ph, gate;
        pat  = (s >= m_ld) ? m_pat : m_pat_old;
        bm   = (s >= m_ld) ? m_bm  : m_bm_old;
        bk   = (s >= m_ld) ? m_bk  : m_bk_old;
        dim  = (k >= m_dim_edge) ? m_dim : m_dim_old;
        ph   = phase_at(s);
        gate = ((s % 8) <= dim);
        v    = '0;
        for (int d = 0; d < 4; d++) begin
            if (gate && !bk[d] && !(bm[d] && !ph)) v[d*7 +: 7] = pat[d*7 +: 7];
        end
        return v;
    endfunction

    task automatic push_frame(input int k);
        logic [27:0] v;
        logic [3:0]  an;
        logic [6:0]  ss;
        int          idx;
        v   = model_vis(k - 1, k);
        idx = ((k - 1) / 5) % 4;
        an  = ~(4'b0001 << idx);
        ss  = ~v[idx*7 +: 7];
        sb.push_back('{due: k, sel: 0, exp: ~v});
        sb.push_back('{due: k, sel: 1, exp: {24'd0, an}});
        sb.push_back('{due: k, sel: 2, exp: {21'd0, ss}});
        sb.push_back('{due: k, sel: 3, exp: {27'd0, phase_at(k)}});
    endtask

    task automatic push_range(input int first, input int last);
        for (int k = first; k <= last; k++) push_frame(k);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_dim(input int d);
        dim_level  = 3'(d);
        m_dim_old  = m_dim;
        m_dim      = d;
        m_dim_edge = cyc + 1;
    endtask

    // Called at a falling edge; load is captured on the next rising edge.
    task automatic do_load(input logic [27:0] pat, input logic [3:0] bm,
                           input logic [3:0] bk, input int last);
        int l;
        l          = cyc + 1;
        seg_in     = pat;
        blink_mask = bm;
        blank_mask = bk;
        load       = 1'b1;
        if (bm != m_bm) begin
            m_base_prev = m_base;
            m_base      = l;
        end
        m_pat_old = m_pat;  m_pat = pat;
        m_bm_old  = m_bm;   m_bm  = bm;
        m_bk_old  = m_bk;   m_bk  = bk;
        m_ld      = l;
        push_range(l, last);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic model_reset();
        m_pat = '0; m_pat_old = '0;
        m_bm  = '0; m_bm_old  = '0;
        m_bk  = '0; m_bk_old  = '0;
        m_ld  = 0;  m_base = 0; m_base_prev = 0;
    endtask

    always @(negedge clk) begin : monitor
        sb_entry_t   e;
        logic [31:0] got;
        string       name;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                case (e.sel)
                    0:       begin got = {4'd0, seg_out};      name = "seg_out";     end
                    1:       begin got = {28'd0, scan_an};     name = "scan_an";     end
                    2:       begin got = {25'd0, scan_seg};    name = "scan_seg";    end
                    default: begin got = {31'd0, blink_phase}; name = "blink_phase"; end
                endcase
                if (e.due != cyc) check("sb_missed_due", cyc, e.due);
                else              check($sformatf("%s@%0d", name, e.due), got, {4'd0, e.exp});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lit;
        model_reset();
        m_dim = 7; m_dim_old = 7; m_dim_edge = 0;

        #12;
        check("rst_seg_out",     {4'd0, seg_out},      32'h0FFFFFFF);
        check("rst_scan_an",     {28'd0, scan_an},     32'hF);
        check("rst_scan_seg",    {25'd0, scan_seg},    32'h7F);
        check("rst_blink_phase", {31'd0, blink_phase}, 32'h1);

        @(negedge clk);
        rst_n = 1'b1;

        do_load(28'h0000006, 4'b0000, 4'b0000, 4);
        wait_cyc(4);
        do_load(PAT_B, 4'b0001, 4'b0000, 40);   // blink digit 0
        wait_cyc(40);
        do_load(PAT_B, 4'b0011, 4'b0000, 50);   // mask change during off half
        wait_cyc(50);
        do_load(PAT_C, 4'b0011, 4'b0000, 70);   // unchanged mask on terminal count
        wait_cyc(70);
        do_load(PAT_C, 4'b0100, 4'b0000, 80);   // changed mask on terminal count
        wait_cyc(80);

        set_dim(0);
        push_range(81, 100);
        wait_cyc(84);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            if (seg_out[27:21] != 7'h7F) lit++;
            @(negedge clk);
        end
        check("dim0_lit_count_16cyc", lit, 2);

        set_dim(7);
        do_load(PAT_C, 4'b0100, 4'b1111, 115);
        wait_cyc(115);
        do_load(PAT_C, 4'b0100, 4'b0000, 120);
        wait_cyc(120);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("sb_drain_pre_reset", sb.size(), 0);
        check("midrst_seg_out",     {4'd0, seg_out},      32'h0FFFFFFF);
        check("midrst_scan_an",     {28'd0, scan_an},     32'hF);
        check("midrst_scan_seg",    {25'd0, scan_seg},    32'h7F);
        check("midrst_blink_phase", {31'd0, blink_phase}, 32'h1);

        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        push_range(1, 12);
        wait_cyc(13);
        check("sb_drain_end", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_engine.md
# seg_display_engine

Parametrised successor to the clock's display-control stage. It takes pre-decoded 7-segment patterns for N digits and latches them through a double buffer so a mid-update never shows on the display. It applies per-digit blink and blanking plus global PWM brightness. It drives either static per-digit outputs or a time-multiplexed scan bus (shared segment lines plus digit anodes). It sits between the decoder and the board pins.

## Interface
- NUM_DIGITS, 8, digit count (1..16)
- CLK_HZ, 50_000_000, clk frequency in Hz
- BLINK_HZ, 2, full blink cycles per second (one on half plus one off half)
- SCAN_HZ, 1000, full-frame refresh rate in multiplexed mode
- MUX_MODE, 0, 0 = static outputs only, 1 = scan outputs active (static outputs still driven)
- ACTIVE_LOW, 1, 1 = all segment/anode outputs inverted (segment lit = 0)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- seg_in  in  7*NUM_DIGITS  decoded patterns; digit 0 at [6:0]; 1 = segment lit
- blink_mask  in  NUM_DIGITS  1 = digit blinks
- blank_mask  in  NUM_DIGITS  1 = digit forced off
- load  in  1  single-cycle strobe; captures seg_in and both masks into the shadow
- dim_level  in  3  brightness 0..7; sampled every cycle, not shadowed
- seg_out  out  7*NUM_DIGITS  static per-digit segments
- scan_seg  out  7  multiplexed segment bus
- scan_an  out  NUM_DIGITS  one-hot digit enable
- blink_phase  out  1  1 = on half, 0 = off half

## Operation
- Shadow registers hold pattern, blink mask and blank mask. They update only on a clock edge with load=1.
- Blink divider: BLINK_DIV = CLK_HZ/(2*BLINK_HZ).
  - Counts 0..BLINK_DIV-1.
  - blink_phase toggles when the count reaches BLINK_DIV-1.
- Blink restart: on load with a new blink_mask different from the current shadow mask, the counter clears and blink_phase forces to 1. The newly selected item is therefore visible immediately.
- A digit shows blank when any of the following holds:
  - its blank_mask bit is 1;
  - its blink_mask bit is 1 and blink_phase=0;
  - the PWM gate is 0.
- PWM: 3-bit free-running counter pwm_cnt, incrementing every clk. Gate = (pwm_cnt <= dim_level).
  - dim_level 7 = always on.
  - dim_level 0 = lit 1 cycle in 8.
- Scan divider: SCAN_DIV = CLK_HZ/(SCAN_HZ*NUM_DIGITS).
  - At terminal count, scan index advances 0→1→…→NUM_DIGITS-1→0.
  - scan_an is one-hot at the index.
  - scan_seg is the post-blink/blank/PWM pattern of that digit.
- MUX_MODE=0: scan_an and scan_seg are held at the off level.
- Polarity inversion (ACTIVE_LOW) is applied last, at the output registers.
- Elaboration error if BLINK_DIV<1, or if SCAN_DIV<1 while MUX_MODE=1.

## Timing
- Reset values:
  - shadow = 0;
  - blink counter = 0 and blink_phase = 1;
  - pwm_cnt = 0;
  - scan index = 0;
  - seg_out, scan_seg and scan_an at the off level (all ones if ACTIVE_LOW, else all zeros).
- All outputs are registered.
- Latency from load to seg_out is 2 cycles: the shadow updates at edge N+1 and the output register at edge N+2. Scan outputs have the same latency for the currently selected digit.
- dim_level and blink_phase take effect on the output 1 cycle after they change.
- Simultaneous events:
  - load coinciding with blink terminal count, with the mask changed: the restart wins and phase = 1.
  - Mask unchanged: the toggle proceeds.
- load held high for several cycles re-captures every cycle. Restart applies only on cycles where the mask differs.
- Reset asserted mid-frame immediately forces outputs to the off level, independent of clk. After release, scan restarts at digit 0 and blink restarts in the on phase.
- Scan index changes exactly once per SCAN_DIV cycles. The anode and segments switch on the same edge, with no ghost cycle.

## Structure
- Shared package seg_display_pkg:
  - SEG_W = 7;
  - SEG_OFF pattern;
  - a clog2 helper;
  - a function computing divider values from the parameters.
- Sub-module seg_tick_gen, parametrised on DIV:
  - counter with synchronous clear input;
  - outputs a single-cycle tick;
  - instantiated for the blink divider and the scan divider.
- The remaining logic (shadow, masking, PWM, scan select, polarity) stays in the top.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_HZ=100, BLINK_HZ=5 (BLINK_DIV=10), SCAN_HZ=5 (SCAN_DIV=5), MUX_MODE=1, ACTIVE_LOW=1.

- **Reset:** assert rst_n=0 asynchronously mid-cycle → seg_out=28'hFFFFFFF and scan_an=4'hF at once; after release, blink_phase=1.
- **Load latency:** seg_in=28'h0000006 (digit 0 shows "1"), load for 1 cycle, dim_level=7 → seg_out[6:0]=7'h79 exactly 2 cycles after the load edge.
- **Blink:** blink_mask=4'b0001 loaded → digit 0 is lit for 10 cycles and blank (7'h7F) for 10 cycles; digits 1–3 are unaffected.
- **Blink restart:** load a changed mask while in the off phase → blink_phase=1 next cycle and the counter restarts.
- **Scan:** scan_an sequence is 4'hE,4'hD,4'hB,4'h7, 5 cycles each, wrapping to 4'hE; scan_seg matches the selected digit on the same cycle.
- **Dim:** dim_level=0 → each digit is lit exactly 1 cycle in every 8; blank_mask=4'b1111 → all outputs off regardless of blink or dim.
